fm_sample_scheduler: RTL and testbench
======================================

# fm_sample_scheduler

Sits between the UART receiver and the carrier NCO of the FM transmitter, running in the sys_clk domain. It parses the received byte stream into audio samples and channel-select commands, and buffers samples in a FIFO. Samples are released to the NCO at a fixed audio rate, with prefill and underrun control. Each cycle it presents the registered NCO phase step: the selected channel's carrier step plus the frequency deviation.

## Interface
Parameters:
- SAMPLE_DIV, 21701: sys_clk cycles per audio sample (250 MHz / 11520 Hz).
- CARRIER_BASE, 32'h5C28_F5C2: phase step for channel 0 (90 MHz).
- CH_SPACING, 32'h0034_6DC6: phase step per channel (200 kHz).
- NUM_CH, 16: number of valid channels, at most 16.
- DEV_SHIFT, 13: left shift applied to the sample to form the deviation.
- FIFO_DEPTH, 16: sample FIFO depth, a power of two.
- PREFILL, 8: FIFO level required to start playback.

Ports:
- sys_clk in 1: system clock.
- sys_rst in 1: asynchronous, active-high reset.
- i_dat in 8: received UART byte.
- i_dat_vld in 1: one-cycle strobe marking i_dat valid.
- i_clr_status in 1: clears the sticky flags.
- o_sample out 8: current signed sample.
- o_phase_step out 32: NCO phase increment.
- o_channel out 4: selected channel.
- o_playing out 1: high in PLAY.
- o_underrun out 1: sticky underrun flag.
- o_overflow out 1: sticky overflow flag.
- o_level out 5: FIFO occupancy, 0..FIFO_DEPTH.

## Operation
Parser (states P_DATA and P_ESC, reset to P_DATA):
- P_DATA, byte ≠ 0xFF: push byte−128 (two's-complement signed); stay in P_DATA.
- P_DATA, byte = 0xFF: go to P_ESC; nothing is pushed.
- P_ESC, byte = 0xFF: push 0x7F, the literal 0xFF sample.
- P_ESC, byte < NUM_CH: o_channel ← byte.
- P_ESC, any other byte: ignored.
- Every P_ESC byte returns the parser to P_DATA.

Pusher:
- A push while the FIFO is full drops the byte and sets o_overflow.
- Exception: a push and a pop in the same cycle while full is allowed; the level is unchanged and there is no overflow.

Rate tick:
- A counter runs 0..SAMPLE_DIV−1 and wraps; tick is asserted at SAMPLE_DIV−1.
- The counter free-runs from reset and is never restarted.

Playback FSM (FILL and PLAY, reset to FILL):
- FILL: o_sample is held at 0 (carrier unmodulated); no pops.
  - Go to PLAY on the first tick with level ≥ PREFILL.
  - That same tick pops the first sample.
- PLAY, tick with level > 0: pop; o_sample ← head.
- PLAY, tick with level = 0: o_sample ← 0; set o_underrun; go to FILL.
- A non-tick cycle never pops.

Phase step:
- o_phase_step ← CARRIER_BASE + o_channel·CH_SPACING + sext32(o_sample) << DEV_SHIFT.
- All terms are 32-bit and the sum wraps modulo 2^32.
- The channel product is a 32-bit multiply by a constant; a 16-entry constant table is also acceptable.

Status flags:
- i_clr_status clears both sticky flags.
- If a set event and a clear occur in the same cycle, set wins.

## Timing
- Reset values:
  - o_sample 0, o_phase_step CARRIER_BASE, o_channel 0.
  - o_playing 0, o_underrun 0, o_overflow 0, o_level 0.
  - Tick counter 0, parser in P_DATA, FSM in FILL.
- Reset is asynchronous. Asserting it mid-stream flushes the FIFO, discards a pending escape and returns the block to the reset values.
- Push: level increments at the edge following the i_dat_vld cycle.
- Pop: o_sample updates at the edge ending the tick cycle.
- o_phase_step follows a change in o_sample or o_channel by one cycle.
- Channel command: o_channel updates one edge after the command byte; o_phase_step updates one edge after that.
- o_playing is registered and changes at the same edge as the FSM state.
- Bytes arriving back-to-back on consecutive cycles are each processed.
- Overflow and underrun each set their flag at the edge of the offending cycle.

## Structure
- Package fm_pkg holds:
  - the parser and playback state enums;
  - the default CARRIER_BASE and CH_SPACING constants;
  - the ESC_BYTE = 8'hFF constant.
- Sub-module fm_sync_fifo: synchronous FIFO with parameterised width and depth.
  - Ports: push, pop, din, dout, full, empty, level.
  - Registered output; head is readable while not empty.
  - Supports push and pop in the same cycle, including when full.

## Test plan
Bench settings: SAMPLE_DIV=4, PREFILL=2, FIFO_DEPTH=4.
- Prefill: push bytes 0x80, 0x90 → o_playing rises at the next tick. o_sample then reads 0x00, and 0x10 one tick later. o_phase_step = 0x5C28F5C2 + (0x10<<13) = 0x5C2AF5C2.
- Escape: send 0xFF 0xFF → one sample 0x7F is pushed. Send 0xFF 0x03 → o_channel = 3 and no push; o_phase_step = 0x5C28F5C2 + 3·0x346DC6 + deviation.
- Invalid command: send 0xFF 0x20 → o_channel is unchanged, nothing is pushed, and the parser is back in P_DATA.
- Underrun: drain the FIFO in PLAY → at the first empty tick o_sample = 0, o_underrun = 1, state returns to FILL. A later i_clr_status clears the flag.
- Overflow: push 5 bytes while in FILL → level = 4 and o_overflow = 1. With a simultaneous push and pop while full → level stays 4 and o_overflow stays 0.
- Reset: assert sys_rst mid-stream and after an 0xFF escape → all outputs return to reset values. The next byte after release is treated as data.

Source files
------------

// File: rtl/fm_pkg.sv
// Shared types and constants for the FM sample scheduler.
package fm_pkg;

  typedef enum logic {PData, PEsc} parse_state_e;
  typedef enum logic {StFill, StPlay} play_state_e;

  localparam logic [31:0] CARRIER_BASE_DEF = 32'h5C28_F5C2;
  localparam logic [31:0] CH_SPACING_DEF   = 32'h0034_6DC6;
  localparam logic [7:0]  ESC_BYTE         = 8'hFF;

endpackage

// File: rtl/fm_sync_fifo.sv
// Synchronous FIFO; accepts a push while full when a pop happens in the same cycle.
module fm_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_level == (AW+1)'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_dout    = r_mem[r_rptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_din;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_level <= r_level + 1'b1;
      else if (w_do_pop && !w_do_push) r_level <= r_level - 1'b1;
    end
  end

endmodule

// File: rtl/fm_sample_scheduler.sv
// Parses UART bytes into samples/channel commands, paces samples to the NCO, forms phase step.
module fm_sample_scheduler
  import fm_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV   = 21701,
  parameter logic [31:0] CARRIER_BASE = CARRIER_BASE_DEF,
  parameter logic [31:0] CH_SPACING   = CH_SPACING_DEF,
  parameter int unsigned NUM_CH       = 16,
  parameter int unsigned DEV_SHIFT    = 13,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned PREFILL      = 8
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [7:0]  i_dat,
  input  logic        i_dat_vld,
  input  logic        i_clr_status,
  output logic [7:0]  o_sample,
  output logic [31:0] o_phase_step,
  output logic [3:0]  o_channel,
  output logic        o_playing,
  output logic        o_underrun,
  output logic        o_overflow,
  output logic [4:0]  o_level
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned DW = $clog2(SAMPLE_DIV + 1);

  parse_state_e r_pstate;
  play_state_e  r_state;
  logic [DW-1:0] r_div;
  logic [7:0]    r_sample;
  logic [31:0]   r_phase;
  logic [3:0]    r_channel;
  logic          r_playing;
  logic          r_underrun;
  logic          r_overflow;

  logic          w_tick;
  logic          w_push;
  logic [7:0]    w_push_data;
  logic          w_pop;
  logic [7:0]    w_head;
  logic          w_full;
  logic          w_empty;
  logic [LW-1:0] w_level;
  logic          w_ovf_set;
  logic          w_unf_set;
  logic [31:0]   w_dev;

  // Offset-binary to two's complement; the escaped 0xFF maps to 0x7F the same way.
  assign w_push_data = i_dat ^ 8'h80;
  assign w_push      = i_dat_vld && (((r_pstate == PData) && (i_dat != ESC_BYTE)) ||
                                     ((r_pstate == PEsc) && (i_dat == ESC_BYTE)));

  assign w_tick    = (r_div == DW'(SAMPLE_DIV - 1));
  assign w_pop     = w_tick && ((r_state == StFill) ? (32'(w_level) >= PREFILL)
                                                    : (w_level != '0));
  assign w_ovf_set = w_push && w_full && !w_pop;
  assign w_unf_set = w_tick && (r_state == StPlay) && (w_level == '0);
  assign w_dev     = 32'({{24{r_sample[7]}}, r_sample}) << DEV_SHIFT;

  fm_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (sys_clk),
    .i_rst   (sys_rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_push_data),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_pstate  <= PData;
      r_channel <= '0;
    end else if (i_dat_vld) begin
      unique case (r_pstate)
        PData: if (i_dat == ESC_BYTE) r_pstate <= PEsc;
        PEsc: begin
          r_pstate <= PData;
          if ((i_dat != ESC_BYTE) && (32'(i_dat) < NUM_CH)) r_channel <= i_dat[3:0];
        end
        default: r_pstate <= PData;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) r_div <= '0;
    else if (w_tick) r_div <= '0;
    else r_div <= r_div + 1'b1;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state   <= StFill;
      r_sample  <= '0;
      r_playing <= 1'b0;
    end else if (w_tick) begin
      unique case (r_state)
        StFill: if (w_pop) begin
          r_state   <= StPlay;
          r_playing <= 1'b1;
          r_sample  <= w_head;
        end
        StPlay: if (w_pop) begin
          r_sample <= w_head;
        end else begin
          r_state   <= StFill;
          r_playing <= 1'b0;
          r_sample  <= '0;
        end
        default: r_state <= StFill;
      endcase
    end
  end

  // Set has priority over clear.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_underrun <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_unf_set) r_underrun <= 1'b1;
      else if (i_clr_status) r_underrun <= 1'b0;
      if (w_ovf_set) r_overflow <= 1'b1;
      else if (i_clr_status) r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) r_phase <= CARRIER_BASE;
    else r_phase <= CARRIER_BASE + 32'(r_channel) * CH_SPACING + w_dev;
  end

  assign o_sample     = r_sample;
  assign o_phase_step = r_phase;
  assign o_channel    = r_channel;
  assign o_playing    = r_playing;
  assign o_underrun   = r_underrun;
  assign o_overflow   = r_overflow;
  assign o_level      = 5'(w_level);

endmodule

// File: tb/tb_fm_sample_scheduler.sv
// Directed bench for fm_sample_scheduler with a short sample period and small FIFO.
module tb_fm_sample_scheduler;

  localparam logic [31:0] BASE = 32'h5C28_F5C2;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [7:0]  i_dat = '0;
  logic        i_dat_vld = 1'b0;
  logic        i_clr_status = 1'b0;
  logic [7:0]  o_sample;
  logic [31:0] o_phase_step;
  logic [3:0]  o_channel;
  logic        o_playing;
  logic        o_underrun;
  logic        o_overflow;
  logic [4:0]  o_level;

  int n_checks = 0;
  int n_bad    = 0;

  fm_sample_scheduler #(
    .SAMPLE_DIV (4),
    .FIFO_DEPTH (4),
    .PREFILL    (2)
  ) u_dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .i_dat        (i_dat),
    .i_dat_vld    (i_dat_vld),
    .i_clr_status (i_clr_status),
    .o_sample     (o_sample),
    .o_phase_step (o_phase_step),
    .o_channel    (o_channel),
    .o_playing    (o_playing),
    .o_underrun   (o_underrun),
    .o_overflow   (o_overflow),
    .o_level      (o_level)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Byte presented at a falling edge is consumed by the next rising edge.
  task automatic send_byte(input logic [7:0] b);
    i_dat     = b;
    i_dat_vld = 1'b1;
    @(negedge sys_clk);
    i_dat_vld = 1'b0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge sys_clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_sample"},   32'(o_sample), 32'h0);
    check_val({tag, "_phase"},    o_phase_step, BASE);
    check_val({tag, "_channel"},  32'(o_channel), 32'h0);
    check_val({tag, "_playing"},  32'(o_playing), 32'h0);
    check_val({tag, "_underrun"}, 32'(o_underrun), 32'h0);
    check_val({tag, "_overflow"}, 32'(o_overflow), 32'h0);
    check_val({tag, "_level"},    32'(o_level), 32'h0);
  endtask

  initial begin
    step(2);
    sys_rst = 1'b0;
    check_reset_vals("rst");

    // Prefill; ticks land on rising edges 4, 8, 12, ... after release.
    send_byte(8'h80);
    send_byte(8'h90);
    check_val("prefill_level", 32'(o_level), 32'd2);
    check_val("prefill_idle", 32'(o_playing), 32'd0);
    step(2);
    check_val("play_start", 32'(o_playing), 32'd1);
    check_val("first_sample", 32'(o_sample), 32'h00);
    check_val("first_pop_level", 32'(o_level), 32'd1);
    step(4);
    check_val("second_sample", 32'(o_sample), 32'h10);
    check_val("drained_level", 32'(o_level), 32'd0);
    step(1);
    check_val("phase_dev", o_phase_step, 32'h5C2A_F5C2);

    // Escaped literal, then channel command straddling the tick at edge 12.
    send_byte(8'hFF);
    send_byte(8'hFF);
    check_val("esc_push_level", 32'(o_level), 32'd1);
    send_byte(8'hFF);
    send_byte(8'h03);
    check_val("chan_set", 32'(o_channel), 32'd3);
    check_val("esc_sample", 32'(o_sample), 32'h7F);
    check_val("chan_no_push", 32'(o_level), 32'd0);
    step(1);
    check_val("phase_chan_dev", o_phase_step, 32'h5CD6_1F14);

    // Underrun at edge 16.
    step(2);
    check_val("unf_sample", 32'(o_sample), 32'h0);
    check_val("unf_flag", 32'(o_underrun), 32'd1);
    check_val("unf_fill", 32'(o_playing), 32'd0);
    step(1);
    check_val("phase_chan_only", o_phase_step, 32'h5CC6_3F14);
    i_clr_status = 1'b1;
    step(1);
    i_clr_status = 1'b0;
    check_val("unf_clear", 32'(o_underrun), 32'd0);

    // Invalid command, then a data byte proves the parser is back in data mode.
    send_byte(8'hFF);
    send_byte(8'h20);
    check_val("bad_cmd_chan", 32'(o_channel), 32'd3);
    check_val("bad_cmd_level", 32'(o_level), 32'd0);
    send_byte(8'h85);
    check_val("after_bad_cmd", 32'(o_level), 32'd1);

    // Tick at edge 24 starts play and pops 0x05; fifth byte hits a full FIFO.
    send_byte(8'h81);
    send_byte(8'h82);
    send_byte(8'h83);
    send_byte(8'h84);
    send_byte(8'h86);
    check_val("ovf_level", 32'(o_level), 32'd4);
    check_val("ovf_flag", 32'(o_overflow), 32'd1);
    check_val("ovf_playing", 32'(o_playing), 32'd1);
    check_val("ovf_sample", 32'(o_sample), 32'h05);
    i_clr_status = 1'b1;
    step(1);
    i_clr_status = 1'b0;
    check_val("ovf_clear", 32'(o_overflow), 32'd0);
    send_byte(8'h87);
    check_val("full_pushpop_level", 32'(o_level), 32'd4);
    check_val("full_pushpop_ovf", 32'(o_overflow), 32'd0);
    check_val("full_pushpop_sample", 32'(o_sample), 32'h01);

    // Reset mid-stream with an escape pending.
    send_byte(8'hFF);
    sys_rst = 1'b1;
    #2;
    check_reset_vals("mid_rst");
    step(1);
    sys_rst = 1'b0;
    send_byte(8'h03);
    check_val("post_rst_chan", 32'(o_channel), 32'd0);
    check_val("post_rst_level", 32'(o_level), 32'd1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
